seq_multiplier: RTL and testbench



---
 rtl/alu_pkg.sv | 14 +
 rtl/seq_multiplier_add_w.sv | 24 ++
 rtl/seq_multiplier.sv | 105 ++++++++++
 tb/tb_seq_multiplier.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: multiplier FSM states, default datapath width, opcodes.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mulState_t;

    localparam int unsigned MUL_WIDTH = 32;

    localparam logic [3:0] OP_MUL = 4'd2;

endpackage

// File: rtl/seq_multiplier_add_w.sv
// WIDTH-bit ripple-carry adder built from full-adder cells, carry out exposed.
module add_w #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic carry;

    // Carry ripples through a variable so the chain is not a self-referencing vector.
    always_comb begin
        sum   = '0;
        carry = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            sum[i] = x[i] ^ y[i] ^ carry;
            carry  = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/seq_multiplier.sv
// Unsigned shift-add multiplier, one iteration per clock through add_w.
// Optional SEQ_MULTIPLIER_EARLY_TERM_EN ends RUN once no multiplier bits remain set.
module seq_multiplier
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH,
    parameter int unsigned CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

    mulState_t        state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mq;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   s;
    logic               c;
    logic [WIDTH-1:0]   accNext;
    logic [WIDTH-1:0]   mqNext;
    logic [CNT_W-1:0]   cntNext;
    logic               finish;
    logic [2*WIDTH-1:0] finProduct;

    assign addend = mq[0] ? mcand : '0;

    add_w #(.WIDTH(WIDTH)) adder (
        .x    (acc),
        .y    (addend),
        .sum  (s),
        .cout (c)
    );

    assign accNext = {c, s[WIDTH-1:1]};
    assign mqNext  = {s[0], mq[WIDTH-1:1]};
    assign cntNext = cnt + 1'b1;

`ifdef SEQ_MULTIPLIER_EARLY_TERM_EN
    logic [WIDTH-1:0] pending;
    logic [CNT_W-1:0] remaining;

    // Low WIDTH-cntNext bits of mqNext are the unconsumed multiplier bits;
    // once they are zero the rest of the run would only shift.
    assign pending    = mqNext << cntNext;
    assign remaining  = LAST - cntNext;
    assign finish     = (pending == '0);
    assign finProduct = {accNext, mqNext} >> remaining;
`else
    assign finish     = (cntNext == LAST);
    assign finProduct = {accNext, mqNext};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            mcand   <= '0;
            acc     <= '0;
            mq      <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mcand <= a;
                        mq    <= b;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc <= accNext;
                    mq  <= mqNext;
                    cnt <= cntNext;
                    if (finish) begin
                        product <= finProduct;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier against a plain-arithmetic reference.
module tb_seq_multiplier;

    localparam int unsigned W = 32;
    localparam int unsigned BOUND = 100;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int passCnt  = 0;
    int checkCnt = 0;

    seq_multiplier #(.WIDTH(W), .CNT_W(6)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] refProduct(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] xw;
        logic [2*W-1:0] yw;
        xw = {{W{1'b0}}, x};
        yw = {{W{1'b0}}, y};
        return xw * yw;
    endfunction

    function automatic int refLatency(input logic [W-1:0] y);
`ifdef SEQ_MULTIPLIER_EARLY_TERM_EN
        int lat;
        lat = 1;
        for (int i = 0; i < int'(W); i++)
            if (y[i]) lat = i + 1;
        return lat;
`else
        return int'(W) + 0 * int'(y[0]);
`endif
    endfunction

    // Pulses start for one edge, then counts edges until done; records busy behaviour.
    task automatic runOp(input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [2*W-1:0] prod, output int lat,
                         output bit busyOk, output bit timedOut);
        @(negedge clk);
        a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom;
        busyOk = (busy === 1'b1) && (done === 1'b0);
        lat = 0;
        timedOut = 1'b1;
        for (int k = 0; k < int'(BOUND); k++) begin
            @(posedge clk); #1;
            lat++;
            if (done === 1'b1) begin
                timedOut = 1'b0;
                if (busy !== 1'b0) busyOk = 1'b0;
                break;
            end
            if (busy !== 1'b1) busyOk = 1'b0;
        end
        prod = product;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; a = '1; b = '1;
        repeat (2) @(posedge clk);
        #1;
        checkCnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else passCnt++;
        checkCnt++;
        if (done !== 1'b0) $display("FAIL reset_done got=%b want=0", done); else passCnt++;
        checkCnt++;
        if (product !== '0) $display("FAIL reset_product got=%h want=0", product); else passCnt++;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
    endtask

    task automatic test_directed;
        logic [W-1:0] ta [5];
        logic [W-1:0] tb [5];
        logic [2*W-1:0] want [5];
        logic [2*W-1:0] got;
        int lat;
        bit busyOk, to;
        ta[0] = 32'd3;          tb[0] = 32'd5;          want[0] = 64'h0000_0000_0000_000F;
        ta[1] = 32'hFFFF_FFFF;  tb[1] = 32'hFFFF_FFFF;  want[1] = 64'hFFFF_FFFE_0000_0001;
        ta[2] = 32'd0;          tb[2] = 32'h1234_5678;  want[2] = 64'h0;
        ta[3] = 32'h8000_0000;  tb[3] = 32'd2;          want[3] = 64'h1_0000_0000;
        ta[4] = 32'd100;        tb[4] = 32'd0;          want[4] = 64'h0;
        for (int i = 0; i < 5; i++) begin
            runOp(ta[i], tb[i], got, lat, busyOk, to);
            checkCnt++;
            if (to) $display("FAIL dir%0d_timeout no done within %0d cycles", i, BOUND);
            else passCnt++;
            checkCnt++;
            if (got !== want[i]) $display("FAIL dir%0d_product got=%h want=%h", i, got, want[i]);
            else passCnt++;
            checkCnt++;
            if (lat != refLatency(tb[i])) $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, refLatency(tb[i]));
            else passCnt++;
            checkCnt++;
            if (!busyOk) $display("FAIL dir%0d_busy got=bad want=high_only_during_run", i);
            else passCnt++;
        end
    endtask

    task automatic test_early_term_cases;
        logic [W-1:0] ta [3];
        logic [W-1:0] tb [3];
        logic [2*W-1:0] got;
        int lat;
        bit busyOk, to;
        ta[0] = 32'd100;   tb[0] = 32'd1;
        ta[1] = 32'hDEAD;  tb[1] = 32'd0;
        ta[2] = 32'd3;     tb[2] = 32'h8000_0000;
        for (int i = 0; i < 3; i++) begin
            runOp(ta[i], tb[i], got, lat, busyOk, to);
            checkCnt++;
            if (lat != refLatency(tb[i]) || to)
                $display("FAIL et%0d_latency got=%0d want=%0d", i, lat, refLatency(tb[i]));
            else passCnt++;
            checkCnt++;
            if (got !== refProduct(ta[i], tb[i]))
                $display("FAIL et%0d_product got=%h want=%h", i, got, refProduct(ta[i], tb[i]));
            else passCnt++;
        end
    endtask

    task automatic test_random;
        logic [W-1:0] x, y;
        logic [2*W-1:0] got;
        int lat;
        bit busyOk, to;
        for (int i = 0; i < 24; i++) begin
            x = $urandom;
            y = $urandom;
            if (i % 3 == 1) y = y >> $urandom_range(W - 1, 0);
            if (i % 6 == 2) x = x >> $urandom_range(W - 1, 0);
            runOp(x, y, got, lat, busyOk, to);
            checkCnt++;
            if (to || got !== refProduct(x, y))
                $display("FAIL rand%0d_product a=%h b=%h got=%h want=%h", i, x, y, got, refProduct(x, y));
            else passCnt++;
            checkCnt++;
            if (lat != refLatency(y))
                $display("FAIL rand%0d_latency got=%0d want=%0d", i, lat, refLatency(y));
            else passCnt++;
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        bit seenDone;
        @(negedge clk);
        a = 32'd2; b = 32'd2; start = 1'b1;
        @(posedge clk); #1;
        a = 32'd7; b = 32'd9;   // start stays high through RUN and must be ignored
        lat = 0; seenDone = 1'b0;
        for (int k = 0; k < int'(BOUND); k++) begin
            @(posedge clk); #1;
            lat++;
            if (done === 1'b1) begin seenDone = 1'b1; break; end
        end
        checkCnt++;
        if (!seenDone || lat != refLatency(32'd2))
            $display("FAIL b2b_first_latency got=%0d want=%0d", lat, refLatency(32'd2));
        else passCnt++;
        checkCnt++;
        if (product !== refProduct(32'd2, 32'd2))
            $display("FAIL b2b_first_product got=%h want=%h", product, refProduct(32'd2, 32'd2));
        else passCnt++;
        // start still high in DONE: accepted on this edge
        @(posedge clk); #1;
        start = 1'b0;
        checkCnt++;
        if (busy !== 1'b1 || done !== 1'b0)
            $display("FAIL b2b_accept busy=%b done=%b want busy=1 done=0", busy, done);
        else passCnt++;
        lat = 0; seenDone = 1'b0;
        for (int k = 0; k < int'(BOUND); k++) begin
            @(posedge clk); #1;
            lat++;
            if (done === 1'b1) begin seenDone = 1'b1; break; end
        end
        checkCnt++;
        if (!seenDone || lat != refLatency(32'd9))
            $display("FAIL b2b_second_latency got=%0d want=%0d", lat, refLatency(32'd9));
        else passCnt++;
        checkCnt++;
        if (product !== 64'd63)
            $display("FAIL b2b_second_product got=%h want=%h", product, 64'd63);
        else passCnt++;
    endtask

    task automatic test_hold;
        logic [2*W-1:0] held;
        int badDone, badProd;
        held = product;
        badDone = 0; badProd = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            a = $urandom; b = $urandom; start = 1'b0;
            @(posedge clk); #1;
            if (done !== 1'b0) badDone++;
            if (product !== held) badProd++;
        end
        checkCnt++;
        if (badDone != 0) $display("FAIL hold_done got=%0d_pulses want=0", badDone); else passCnt++;
        checkCnt++;
        if (badProd != 0) $display("FAIL hold_product got=%0d_changes want=0", badProd); else passCnt++;
    endtask

    task automatic test_reset_mid;
        int spurious;
        @(negedge clk);
        a = 32'h1357_9BDF; b = 32'hFFFF_FFFF; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checkCnt++;
        if (busy !== 1'b0) $display("FAIL midrst_busy got=%b want=0", busy); else passCnt++;
        checkCnt++;
        if (done !== 1'b0) $display("FAIL midrst_done got=%b want=0", done); else passCnt++;
        checkCnt++;
        if (product !== '0) $display("FAIL midrst_product got=%h want=0", product); else passCnt++;
        @(negedge clk);
        rst = 1'b0;
        spurious = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) spurious++;
        end
        checkCnt++;
        if (spurious != 0) $display("FAIL midrst_quiet got=%0d_active_cycles want=0", spurious); else passCnt++;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; a = '0; b = '0;
        test_reset;
        test_directed;
        test_early_term_cases;
        test_random;
        test_back_to_back;
        test_hold;
        test_reset_mid;
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
